// File: rtl/text_seq_pkg.sv
// Shared types and constants for the text cursor sequencer: FSM states,
// control-code values and cursor-update opcodes.
package text_seq_pkg;

    localparam int COORD_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ADVANCE
    } state_t;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_TAB = 8'h09;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;

    // Cursor-update opcodes understood by text_cursor_advance
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_NEXT = 3'd1;
    localparam logic [2:0] OP_CR   = 3'd2;
    localparam logic [2:0] OP_LF   = 3'd3;
    localparam logic [2:0] OP_FF   = 3'd4;
    localparam logic [2:0] OP_BS   = 3'd5;
    localparam logic [2:0] OP_TAB  = 3'd6;
    localparam logic [2:0] OP_HOME = 3'd7;

endpackage

// File: rtl/text_cursor_advance.sv
// Pixel-coordinate text cursor: applies one opcode per cycle with
// line-end and bottom-of-screen wrap (no scrolling).
module text_cursor_advance
    import text_seq_pkg::*;
#(
    parameter int LINE_WIDTH   = 640,
    parameter int NUM_LINES    = 480,
    parameter int CHAR_PITCH_X = 24,
    parameter int CHAR_PITCH_Y = 27,
    parameter int TAB_STOP     = 4
) (
    input  logic               clk,
    input  logic               arst,
    input  logic [2:0]         op,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y
);

    localparam int TAB_W = TAB_STOP * CHAR_PITCH_X;

    logic [10:0]        nx;
    logic [10:0]        ny;
    logic [10:0]        tx;
    logic [COORD_W-1:0] y_adv;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;

    always_comb begin
        nx    = {1'b0, x} + 11'(CHAR_PITCH_X);
        ny    = {1'b0, y} + 11'(CHAR_PITCH_Y);
        tx    = ({1'b0, x} / 11'(TAB_W) + 11'd1) * 11'(TAB_W);
        // Line advance target: next row, or back to the top when it would not fit
        y_adv = (ny + 11'(CHAR_PITCH_Y) > 11'(NUM_LINES)) ? '0 : ny[COORD_W-1:0];
        x_nxt = x;
        y_nxt = y;
        case (op)
            OP_NEXT: begin
                if (nx + 11'(CHAR_PITCH_X) > 11'(LINE_WIDTH)) begin
                    x_nxt = '0;
                    y_nxt = y_adv;
                end else begin
                    x_nxt = nx[COORD_W-1:0];
                end
            end
            OP_CR: x_nxt = '0;
            OP_LF: begin
                x_nxt = '0;
                y_nxt = y_adv;
            end
            OP_FF, OP_HOME: begin
                x_nxt = '0;
                y_nxt = '0;
            end
            OP_BS: begin
                if (x >= COORD_W'(CHAR_PITCH_X)) x_nxt = x - COORD_W'(CHAR_PITCH_X);
            end
            OP_TAB: begin
                if (tx > 11'(LINE_WIDTH - CHAR_PITCH_X)) begin
                    x_nxt = '0;
                    y_nxt = y_adv;
                end else begin
                    x_nxt = tx[COORD_W-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_nxt;
            y <= y_nxt;
        end
    end

endmodule

// File: rtl/text_cursor_sequencer.sv
// Turns a character byte stream into glyph-write commands for display_char.
// Build option: TEXT_SEQ_TAB_EXPAND_EN makes 0x09 a tab-stop control code.
module text_cursor_sequencer
    import text_seq_pkg::*;
#(
    parameter int LINE_WIDTH   = 640,
    parameter int NUM_LINES    = 480,
    parameter int CHAR_PITCH_X = 24,
    parameter int CHAR_PITCH_Y = 27,
    parameter int ACK_TIMEOUT  = 15,
    parameter int TAB_STOP     = 4
) (
    input  logic         clk,
    input  logic         arst,
    input  logic [7:0]   char_in,
    input  logic         char_valid,
    output logic         char_ready,
    input  logic [15:0]  fg_color,
    input  logic         cursor_home,
    output logic [9:0]   raster_x,
    output logic [9:0]   raster_y,
    output logic [7:0]   char_select,
    output logic [15:0]  wdata,
    output logic         start_write,
    input  logic         busy,
    output logic         idle
);

`ifdef TEXT_SEQ_TAB_EXPAND_EN
    localparam bit TAB_EN = 1'b1;
`else
    localparam bit TAB_EN = 1'b0;
`endif

    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       op;
    logic             accept;
    logic [CNT_W-1:0] ack_cnt;
    logic             pending_home;

    assign accept = char_valid & char_ready;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        op        = OP_NONE;
        case (state)
            S_IDLE: begin
                if (cursor_home) begin
                    op = OP_HOME;
                end else if (accept) begin
                    case (char_in)
                        CC_CR:   op = OP_CR;
                        CC_LF:   op = OP_LF;
                        CC_FF:   op = OP_FF;
                        CC_BS:   op = OP_BS;
                        CC_TAB: begin
                            if (TAB_EN) op = OP_TAB;
                            else        state_nxt = S_START;
                        end
                        default: state_nxt = S_START;
                    endcase
                end
            end
            S_START: state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                // A writer that never raises busy is treated as having finished
                if (busy)                     state_nxt = S_WAIT_DONE;
                else if (ack_cnt == ACK_LAST) state_nxt = S_ADVANCE;
            end
            S_WAIT_DONE: begin
                if (!busy) state_nxt = S_ADVANCE;
            end
            S_ADVANCE: begin
                op        = (pending_home || cursor_home) ? OP_HOME : OP_NEXT;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        start_write = (state == S_START);
        char_ready  = (state == S_IDLE) && !busy && !cursor_home && !arst;
        idle        = (state == S_IDLE) && !pending_home;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            char_select  <= '0;
            wdata        <= '0;
            ack_cnt      <= '0;
            pending_home <= 1'b0;
        end else begin
            if (accept) begin
                char_select <= char_in;
                wdata       <= fg_color;
            end
            if (state == S_WAIT_ACK) ack_cnt <= ack_cnt + 1'b1;
            else                     ack_cnt <= '0;
            if (state == S_ADVANCE)                    pending_home <= 1'b0;
            else if (state != S_IDLE && cursor_home)   pending_home <= 1'b1;
        end
    end

    text_cursor_advance #(
        .LINE_WIDTH  (LINE_WIDTH),
        .NUM_LINES   (NUM_LINES),
        .CHAR_PITCH_X(CHAR_PITCH_X),
        .CHAR_PITCH_Y(CHAR_PITCH_Y),
        .TAB_STOP    (TAB_STOP)
    ) u_advance (
        .clk (clk),
        .arst(arst),
        .op  (op),
        .x   (raster_x),
        .y   (raster_y)
    );

endmodule

// File: tb/tb_text_cursor_sequencer.sv
// Bench for text_cursor_sequencer: write commands are checked by a monitor
// against an expected queue; cursor position and flags are checked directly.
module tb_text_cursor_sequencer;

    localparam int W = 44;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [7:0]  char_in = '0;
    logic        char_valid = 1'b0;
    logic        char_ready;
    logic [15:0] fg_color = '0;
    logic        cursor_home = 1'b0;
    logic [9:0]  raster_x;
    logic [9:0]  raster_y;
    logic [7:0]  char_select;
    logic [15:0] wdata;
    logic        start_write;
    logic        busy = 1'b0;
    logic        idle;

    logic [W-1:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  busy_en = 1'b1;

    text_cursor_sequencer dut (
        .clk        (clk),
        .arst       (arst),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .fg_color   (fg_color),
        .cursor_home(cursor_home),
        .raster_x   (raster_x),
        .raster_y   (raster_y),
        .char_select(char_select),
        .wdata      (wdata),
        .start_write(start_write),
        .busy       (busy),
        .idle       (idle)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic expect_write(input int x, input int y, input logic [7:0] c, input logic [15:0] d);
        exp_q.push_back({10'(x), 10'(y), c, d});
    endtask

    // display_char model: busy high for 3 cycles after each start_write
    initial begin
        forever begin
            @(negedge clk);
            if (start_write && busy_en) begin
                @(posedge clk); #1 busy = 1'b1;
                repeat (3) @(posedge clk);
                #1 busy = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (start_write) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected: got x=%0d y=%0d char=%0h, expected no write",
                             raster_x, raster_y, char_select);
                end else begin
                    e = exp_q.pop_front();
                    if ({raster_x, raster_y, char_select, wdata} !== e) begin
                        errors++;
                        $display("FAIL write_cmd: got x=%0d y=%0d char=%0h wdata=%0h, expected x=%0d y=%0d char=%0h wdata=%0h",
                                 raster_x, raster_y, char_select, wdata,
                                 e[43:34], e[33:24], e[23:16], e[15:0]);
                    end
                end
            end
        end
    end

    // driver tasks (called at posedge+#1)
    task automatic send_char(input logic [7:0] c, input logic [15:0] col, output int tries);
        bit rdy;
        tries = 0;
        char_in = c;
        fg_color = col;
        char_valid = 1'b1;
        do begin
            @(negedge clk);
            rdy = char_ready;
            @(posedge clk); #1;
            tries++;
        end while (!rdy && tries < 200);
        char_valid = 1'b0;
        if (!rdy) check("accept_timeout", 0, 1);
    endtask

    task automatic send(input logic [7:0] c);
        int t;
        send_char(c, 16'h5A00 | 16'(c), t);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!idle && n < 200);
        @(posedge clk); #1;
        if (n >= 200) check("idle_timeout", 0, 1);
    endtask

    task automatic wait_busy();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!busy && n < 100);
        if (n >= 100) check("busy_timeout", 0, 1);
    endtask

    task automatic check_cursor(input string name, input int x, input int y);
        @(negedge clk);
        check({name, "_x"}, 32'(raster_x), 32'(x));
        check({name, "_y"}, 32'(raster_y), 32'(y));
        @(posedge clk); #1;
    endtask

    initial begin
        int t;
        int n;

        // reset values while arst is held
        @(negedge clk);
        check("rst_x", 32'(raster_x), 0);
        check("rst_y", 32'(raster_y), 0);
        check("rst_char_select", 32'(char_select), 0);
        check("rst_wdata", 32'(wdata), 0);
        check("rst_start_write", 32'(start_write), 0);
        check("rst_char_ready", 32'(char_ready), 0);
        check("rst_idle", 32'(idle), 1);
        @(posedge clk); #1 arst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(char_ready), 1);
        @(posedge clk); #1;

        // "AB"
        expect_write(0, 0, 8'h41, 16'h1234);
        send_char(8'h41, 16'h1234, t);
        wait_idle();
        expect_write(24, 0, 8'h42, 16'hABCD);
        send_char(8'h42, 16'hABCD, t);
        wait_idle();
        check_cursor("ab_final", 48, 0);

        // 27 printable chars from home: line wrap after 26 columns
        send(8'h0C);
        check_cursor("ff", 0, 0);
        for (int i = 0; i < 27; i++) begin
            expect_write((i % 26) * 24, (i / 26) * 27, 8'(8'h41 + i), 16'(16'h0100 + i));
            send_char(8'(8'h41 + i), 16'(16'h0100 + i), t);
            wait_idle();
        end
        check_cursor("wrap27", 24, 27);

        // bottom row then LF wraps to the top without drawing
        send(8'h0C);
        for (int i = 0; i < 16; i++) send(8'h0A);
        check_cursor("bottom_row", 0, 432);
        send(8'h0A);
        @(negedge clk);
        check("vwrap_x", 32'(raster_x), 0);
        check("vwrap_y", 32'(raster_y), 0);
        check("vwrap_ready", 32'(char_ready), 1);
        @(posedge clk); #1;
        send(8'h0A);
        expect_write(0, 27, 8'h50, 16'h7777);
        send_char(8'h50, 16'h7777, t);
        check("lf_next_accept_tries", 32'(t), 1);
        wait_idle();

        // backspace from (48,27)
        expect_write(24, 27, 8'h51, 16'h5A51);
        send(8'h51);
        wait_idle();
        check_cursor("bs_start", 48, 27);
        send(8'h08);
        check_cursor("bs1", 24, 27);
        send(8'h08);
        check_cursor("bs2", 0, 27);
        send(8'h08);
        check_cursor("bs3", 0, 27);

        // CR
        expect_write(0, 27, 8'h52, 16'h5A52);
        send(8'h52);
        wait_idle();
        send(8'h0D);
        check_cursor("cr", 0, 27);

        // ack timeout: busy never rises
        busy_en = 1'b0;
        expect_write(0, 27, 8'h54, 16'h5A54);
        send(8'h54);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (raster_x != 10'd24 && n < 100);
        check("timeout_cycles", 32'(n), 18);
        check("timeout_idle", 32'(idle), 1);
        check("timeout_y", 32'(raster_y), 27);
        @(posedge clk); #1;
        busy_en = 1'b1;

        // cursor_home during WAIT_DONE from (72,54)
        send(8'h0C);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 3; i++) begin
            expect_write(i * 24, 54, 8'h61, 16'h5A61);
            send(8'h61);
            wait_idle();
        end
        expect_write(72, 54, 8'h62, 16'h5A62);
        send(8'h62);
        wait_busy();
        @(posedge clk); #1 cursor_home = 1'b1;
        @(posedge clk); #1 cursor_home = 1'b0;
        @(negedge clk);
        check("home_pending_idle", 32'(idle), 0);
        @(posedge clk); #1;
        wait_idle();
        @(negedge clk);
        check("home_wd_x", 32'(raster_x), 0);
        check("home_wd_y", 32'(raster_y), 0);
        check("home_wd_idle", 32'(idle), 1);
        @(posedge clk); #1;

        // arst during WAIT_DONE
        expect_write(0, 0, 8'h63, 16'h5A63);
        send(8'h63);
        wait_idle();
        expect_write(24, 0, 8'h64, 16'hBEEF);
        send_char(8'h64, 16'hBEEF, t);
        wait_busy();
        @(posedge clk); #1 arst = 1'b1;
        @(negedge clk);
        check("arst_x", 32'(raster_x), 0);
        check("arst_y", 32'(raster_y), 0);
        check("arst_char_select", 32'(char_select), 0);
        check("arst_wdata", 32'(wdata), 0);
        check("arst_start_write", 32'(start_write), 0);
        check("arst_char_ready", 32'(char_ready), 0);
        check("arst_idle", 32'(idle), 1);
        @(posedge clk); #1 arst = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // tab
        expect_write(0, 0, 8'h65, 16'h5A65);
        send(8'h65);
        wait_idle();
`ifdef TEXT_SEQ_TAB_EXPAND_EN
        send(8'h09);
        check_cursor("tab", 96, 0);
`else
        expect_write(24, 0, 8'h09, 16'h5A09);
        send(8'h09);
        wait_idle();
        check_cursor("tab_printable", 48, 0);
`endif

        // cursor_home in IDLE
        @(posedge clk); #1 cursor_home = 1'b1;
        @(negedge clk);
        check("home_idle_ready", 32'(char_ready), 0);
        @(posedge clk); #1 cursor_home = 1'b0;
        @(negedge clk);
        check("home_idle_x", 32'(raster_x), 0);
        check("home_idle_ready_after", 32'(char_ready), 1);
        @(posedge clk); #1;

        // foreign busy in IDLE blocks acceptance
        busy = 1'b1;
        @(negedge clk);
        check("foreign_busy_ready", 32'(char_ready), 0);
        @(posedge clk); #1 busy = 1'b0;
        @(negedge clk);
        check("foreign_busy_release", 32'(char_ready), 1);

        repeat (5) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/text_cursor_sequencer.md
Name: text_cursor_sequencer

Overview:
- Upstream stage of display_char. Accepts a byte stream of character codes over a valid/ready handshake and keeps a pixel-coordinate text cursor.
- For each printable code it issues one glyph-write command (raster_x, raster_y, char_select, wdata, start_write) to display_char and waits on its busy.
- Control codes move the cursor without drawing. The cursor auto-wraps at line end and at the bottom of the screen.

Parameters:
- LINE_WIDTH, 640, raster width in pixels
- NUM_LINES, 480, raster height in pixels
- CHAR_PITCH_X, 24, horizontal cursor step in pixels (equals font width)
- CHAR_PITCH_Y, 27, vertical cursor step in pixels (equals font height)
- ACK_TIMEOUT, 15, cycles to wait for busy to rise before treating a write as complete
- TAB_STOP, 4, tab stop spacing in character cells (used only with TAB_EXPAND_EN)

Ports:
- clk  in  1  clock
- arst  in  1  reset, asynchronous, active-high
- char_in  in  8  character code
- char_valid  in  1  char_in is valid
- char_ready  out  1  block accepts char_in this cycle
- fg_color  in  16  pixel value, sampled at char acceptance
- cursor_home  in  1  pulse: cursor to (0,0)
- raster_x  out  10  glyph top-left x to display_char
- raster_y  out  10  glyph top-left y to display_char
- char_select  out  8  glyph code to display_char
- wdata  out  16  pixel value to display_char
- start_write  out  1  one-cycle write strobe to display_char
- busy  in  1  display_char busy
- idle  out  1  FSM in IDLE with no pending work

Behaviour:
- Reset values:
  - raster_x=0, raster_y=0, char_select=0, wdata=0
  - start_write=0, char_ready=0, idle=1
  - FSM state = IDLE
- States: IDLE, START, WAIT_ACK, WAIT_DONE, ADVANCE.
- IDLE:
  - char_ready = !busy & !cursor_home.
  - Acceptance occurs on char_valid & char_ready. Register char_select = char_in and wdata = fg_color.
  - Printable code (not 0x08, 0x0A, 0x0C, 0x0D, nor 0x09 when TAB_EXPAND_EN): go to START.
  - Control code: update the cursor in the same cycle and stay in IDLE, so one control code is accepted per cycle.
- START: start_write=1 for exactly one cycle, then WAIT_ACK. raster_x/raster_y/char_select/wdata are held stable from START until ADVANCE.
- WAIT_ACK:
  - busy=1 -> WAIT_DONE.
  - ACK_TIMEOUT cycles elapse without busy -> ADVANCE (write counted as complete).
  - Counter width is $clog2(ACK_TIMEOUT+1).
- WAIT_DONE: busy=0 -> ADVANCE.
- ADVANCE (1 cycle), then IDLE:
  - Compute nx = raster_x + CHAR_PITCH_X in 11 bits.
  - If nx + CHAR_PITCH_X > LINE_WIDTH: x=0 and perform a line advance.
  - Otherwise x=nx.
- Line advance:
  - ny = raster_y + CHAR_PITCH_Y in 11 bits.
  - If ny + CHAR_PITCH_Y > NUM_LINES: y=0 (wrap to top, no scroll). Otherwise y=ny.
- Control codes:
  - 0x0D (CR): x=0.
  - 0x0A (LF): x=0 plus line advance.
  - 0x0C (FF): x=0, y=0. No clear.
  - 0x08 (BS): if x>=CHAR_PITCH_X then x -= CHAR_PITCH_X, else x unchanged. Never moves up a line.
- Defaults give 26 columns (x max 600) and 17 rows (y max 432).
- cursor_home:
  - In IDLE: x=y=0 that cycle, and char_ready is forced low.
  - In any other state: latched pending. Applied in the ADVANCE cycle, overriding the computed advance.
- busy high in IDLE, from a foreign writer: char_ready=0 until busy drops.
- idle = (state==IDLE) & !pending_home.
- Reset mid-operation: all state returns to reset values immediately. No start_write is emitted after arst deasserts until a new char is accepted.

Optional Feature:
- Macro: TEXT_SEQ_TAB_EXPAND_EN.
- Defined: 0x09 is a control code. x advances to the next multiple of TAB_STOP*CHAR_PITCH_X. If that exceeds LINE_WIDTH-CHAR_PITCH_X, x=0 plus line advance. No glyph is drawn.
- Undefined: 0x09 is printable and drawn like any other code. The TAB_STOP parameter is unused.

Decomposition:
- Package text_seq_pkg:
  - state enum typedef
  - control-code localparams (CC_BS, CC_TAB, CC_LF, CC_FF, CC_CR)
  - coord width constant (10)
- One natural sub-module, text_cursor_advance: combinational plus registered x/y cursor update, taking an opcode (next_char, cr, lf, ff, bs, tab, home). The FSM stays in the top.

Test Plan:
- Send "AB" (0x41, 0x42) with busy emulated 3 cycles high after each start -> two start_write pulses. Coords (0,0) char 0x41, then (24,0) char 0x42; final cursor (48,0).
- 27 printable chars from x=0, y=0 -> the 27th write at (0,27). The 26th write is at (600,0).
- At y=432, send LF -> x=0, y=0 (vertical wrap). No start_write; char_ready stays high, next char accepted the following cycle.
- Cursor (48,27): send BS, BS, BS -> x 24, 0, 0, with y=27 throughout.
- busy never rises after start -> ADVANCE after exactly ACK_TIMEOUT=15 cycles, cursor advanced by 24.
- cursor_home pulsed during WAIT_DONE from (72,54) -> after ADVANCE, cursor is (0,0) and idle=1.
- arst asserted during WAIT_DONE -> all outputs at reset values next cycle. No spurious start_write afterwards.
- With TEXT_SEQ_TAB_EXPAND_EN: tab from x=24 -> x=96.
